branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The module SHALL have one clock domain and a synchronous, active-high reset, with these ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
PCF  in  32  fetch-stage PC (lookup address)
PredTakenF  out  1  prediction: branch taken
PredTargetF  out  32  predicted next PC
BranchE  in  1  EX holds a resolved branch/jal
TakenE  in  1  actual outcome
PCE  in  32  PC of the EX instruction
TargetE  in  32  actual target
PCPlus4E  in  32  fall-through PC
PredTakenE  in  1  prediction carried to EX
PredTargetE  in  32  predicted target carried to EX
MispredictE  out  1  redirect required
RedirectPC  out  32  corrected PC
FlushD  out  1  flush IF/ID register
FlushE  out  1  flush ID/EX register
BranchCount  out  32  resolved-branch count
MispredCount  out  32  misprediction count

REQ-002 Parameter: ENTRIES, default 16, number of table entries (power of 2).

Function
REQ-003 The table SHALL hold ENTRIES entries: valid(1), tag = PC[31:6](26), target(32), ctr(2).
REQ-004 Index SHALL be PC[5:2]; tag SHALL be PC[31:6].
REQ-005 hitF SHALL be true when valid[PCF idx] is set and the stored tag equals PCF[31:6].
REQ-006 PredTakenF SHALL equal hitF && ctr[1], combinationally from PCF.
REQ-007 PredTargetF SHALL be the stored target when PredTakenF is 1; otherwise PCF+4 (mod 2^32).
REQ-008 MispredictE SHALL equal BranchE && ((TakenE != PredTakenE) || (TakenE && PredTakenE && TargetE != PredTargetE)).
REQ-009 RedirectPC SHALL be TargetE when TakenE is 1, else PCPlus4E; it is only meaningful when MispredictE is 1.
REQ-010 FlushD and FlushE SHALL equal MispredictE, combinationally, in the same cycle.
REQ-011 Update SHALL occur on the rising edge when BranchE=1, at index PCE[5:2], with hitE = valid && tag match.
REQ-012 TakenE=1 and hitE: ctr SHALL saturating-increment (max 3); target SHALL be written with TargetE.
REQ-013 TakenE=1 and miss: the entry SHALL be allocated or replaced with valid=1, tag=PCE[31:6], target=TargetE, ctr=2.
REQ-014 TakenE=0 and hitE: ctr SHALL saturating-decrement (min 0); valid, tag and target SHALL be unchanged.
REQ-015 TakenE=0 and miss: no table change.
REQ-016 Counter transitions SHALL be 0->1->2->3 on taken (3 holds) and 3->2->1->0 on not taken (0 holds).
REQ-017 A lookup and an update to the same index in the same cycle: the lookup SHALL return pre-update contents; the new contents are visible from the next cycle.
REQ-018 BranchCount SHALL increment on each edge with BranchE=1; MispredCount SHALL increment on each edge with MispredictE=1.
REQ-019 Both counters SHALL saturate at 32'hFFFF_FFFF; they never wrap.
REQ-020 With BranchE=0, table and counters SHALL hold.

Reset
REQ-021 On a clock edge with reset=1: all valid bits SHALL be cleared, all ctr SHALL be set to 1, and BranchCount and MispredCount SHALL be set to 0; target and tag values are don't-care.
REQ-022 While reset=1, PredTakenF, MispredictE, FlushD and FlushE SHALL be forced to 0, PredTargetF SHALL be PCF+4, and no update SHALL occur.
REQ-023 Reset asserted mid-operation SHALL override any same-edge update; state is fully cleared after one edge.

Verification
REQ-024 After reset, PCF=0x100 -> PredTakenF=0, PredTargetF=0x104, counters=0.
REQ-025 Taken beq: BranchE=1, TakenE=1, PCE=0x100, TargetE=0x120, PredTakenE=0, PCPlus4E=0x104 -> MispredictE=FlushD=FlushE=1, RedirectPC=0x120, MispredCount=1; next cycle PCF=0x100 gives PredTakenF=1, PredTargetF=0x120.
REQ-026 Same branch resolved taken twice more with PredTakenE=1 and PredTargetE=0x120 -> no flush, ctr=3; then four not-taken resolutions -> ctr reaches 0, PredTakenF=0 from the second one onward, and MispredCount increments only on mispredicted resolutions.
REQ-027 Alias: entry at 0x100 installed, then taken branch at PCE=0x140 (same index) -> entry replaced with ctr=2; PCF=0x100 misses, PCF=0x140 hits.
REQ-028 Same-cycle case: PCF=0x100 while an update at 0x100 occurs -> old prediction this cycle, new prediction the next cycle.
REQ-029 reset pulsed for one cycle with a populated table and BranchE=1 -> all lookups miss afterward, counters=0, and no update is applied.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit counters, EX-stage update, redirect and statistics.
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   PCF                             fetch PC used for lookup
//   PredTakenF, PredTargetF         fetch-stage prediction and next PC
//   BranchE, TakenE, PCE, TargetE,  resolved branch information from EX
//   PCPlus4E, PredTakenE,
//   PredTargetE
//   MispredictE, RedirectPC         redirect request and corrected PC
//   FlushD, FlushE                  pipeline flushes on misprediction
//   BranchCount, MispredCount       saturating statistics counters
module branch_predict_unit #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        BranchE,
    input  logic        TakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] TargetE,
    input  logic [31:0] PCPlus4E,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] RedirectPC,
    output logic        FlushD,
    output logic        FlushE,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    logic          valid_q [ENTRIES];
    logic [TW-1:0] tag_q   [ENTRIES];
    logic [31:0]   tgt_q   [ENTRIES];
    logic [1:0]    ctr_q   [ENTRIES];
    logic [IW-1:0] idx_f, idx_e;
    logic          hit_f, hit_e;
    logic [1:0]    ctr_e, ctr_d;
    logic [31:0]   bcnt_q, bcnt_d, mcnt_q, mcnt_d;

    always_comb begin
        idx_f        = PCF[IW+1:2];
        idx_e        = PCE[IW+1:2];
        hit_f        = valid_q[idx_f] && (tag_q[idx_f] == PCF[31:IW+2]);
        hit_e        = valid_q[idx_e] && (tag_q[idx_e] == PCE[31:IW+2]);
        ctr_e        = ctr_q[idx_e];
        PredTakenF   = !reset && hit_f && ctr_q[idx_f][1];
        PredTargetF  = PredTakenF ? tgt_q[idx_f] : PCF + 32'd4;
        MispredictE  = !reset && BranchE &&
                       ((TakenE != PredTakenE) || (TakenE && PredTakenE && (TargetE != PredTargetE)));
        FlushD       = MispredictE;
        FlushE       = MispredictE;
        RedirectPC   = TakenE ? TargetE : PCPlus4E;
        // A taken miss allocates a fresh entry starting weakly taken
        ctr_d        = !hit_e ? 2'd2 :
                       TakenE ? ((ctr_e == 2'd3) ? 2'd3 : ctr_e + 2'd1) :
                                ((ctr_e == 2'd0) ? 2'd0 : ctr_e - 2'd1);
        bcnt_d       = (BranchE && (bcnt_q != '1)) ? bcnt_q + 32'd1 : bcnt_q;
        mcnt_d       = (MispredictE && (mcnt_q != '1)) ? mcnt_q + 32'd1 : mcnt_q;
        BranchCount  = bcnt_q;
        MispredCount = mcnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'd1;
            end
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
            if (BranchE && (TakenE || hit_e))
                ctr_q[idx_e] <= ctr_d;
            if (BranchE && TakenE) begin
                valid_q[idx_e] <= 1'b1;
                tag_q[idx_e]   <= PCE[31:IW+2];
                tgt_q[idx_e]   <= TargetE;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and randomized checks of branch_predict_unit against a behavioural model.
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        BranchE, TakenE, PredTakenE;
    logic [31:0] PCE, TargetE, PCPlus4E, PredTargetE;
    logic        MispredictE, FlushD, FlushE;
    logic [31:0] RedirectPC, BranchCount, MispredCount;

    int checks = 0;
    int failures = 0;

    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    longint      m_bc, m_mc;

    logic [31:0] pool [8] = '{32'h100, 32'h140, 32'h104, 32'h200,
                              32'h1100, 32'h13C, 32'h240, 32'hFFFF_FFFC};

    branch_predict_unit dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .BranchE(BranchE), .TakenE(TakenE), .PCE(PCE), .TargetE(TargetE), .PCPlus4E(PCPlus4E),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
        .RedirectPC(RedirectPC), .FlushD(FlushD), .FlushE(FlushE),
        .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc[31:6]);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    // One pipeline cycle: drive, compare combinational outputs, advance the model, compare counters.
    // use_model makes PredTakenE/PredTargetE what the predictor would have said for PCE.
    task automatic step(input bit rst, input bit br, input bit tk, input logic [31:0] pcf,
                        input logic [31:0] pce, input logic [31:0] tgt, input bit use_model,
                        input bit ptk, input logic [31:0] ptgt);
        bit          e_pt, e_mis, h;
        logic [31:0] e_ptg;
        int          i;
        @(negedge clk);
        if (use_model) begin
            ptk  = m_pred(pce);
            ptgt = ptk ? m_tgt[m_idx(pce)] : pce + 32'd4;
        end
        reset = rst; BranchE = br; TakenE = tk; PCF = pcf; PCE = pce; TargetE = tgt;
        PCPlus4E = pce + 32'd4; PredTakenE = ptk; PredTargetE = ptgt;
        #1;
        e_pt  = !rst && m_pred(pcf);
        e_ptg = e_pt ? m_tgt[m_idx(pcf)] : pcf + 32'd4;
        e_mis = !rst && br && ((tk != ptk) || (tk && ptk && tgt != ptgt));
        chk("pred_taken", {31'd0, PredTakenF}, {31'd0, e_pt});
        chk("pred_target", PredTargetF, e_ptg);
        chk("mispredict", {31'd0, MispredictE}, {31'd0, e_mis});
        chk("flushD", {31'd0, FlushD}, {31'd0, e_mis});
        chk("flushE", {31'd0, FlushE}, {31'd0, e_mis});
        if (e_mis) chk("redirect", RedirectPC, tk ? tgt : pce + 32'd4);
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
            m_bc = 0;
            m_mc = 0;
        end else if (br) begin
            i = m_idx(pce);
            h = m_hit(pce);
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (e_mis && m_mc < 64'hFFFF_FFFF) m_mc++;
            if (tk && h) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tgt;
            end else if (tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = pce[31:6];
                m_tgt[i]   = tgt;
                m_ctr[i]   = 2;
            end else if (h) begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end
        @(posedge clk);
        #1;
        chk("branch_count", BranchCount, m_bc[31:0]);
        chk("mispred_count", MispredCount, m_mc[31:0]);
    endtask

    task automatic lookup(input logic [31:0] pcf);
        step(1'b0, 1'b0, 1'b0, pcf, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] pc, tg;
        reset = 1'b1; BranchE = 1'b0; TakenE = 1'b0; PCF = '0; PCE = '0;
        TargetE = '0; PCPlus4E = '0; PredTakenE = 1'b0; PredTargetE = '0;
        m_bc = 0; m_mc = 0;
        step(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        lookup(32'h100);
        chk("rst_pred_target", PredTargetF, 32'h104);
        // first taken resolution mispredicts and installs the entry
        step(1'b0, 1'b1, 1'b1, 32'h100, 32'h100, 32'h120, 1'b0, 1'b0, 32'h104);
        chk("install_pred", {31'd0, PredTakenF}, 32'd1);
        chk("install_target", PredTargetF, 32'h120);
        chk("install_mispred", MispredCount, 32'd1);
        step(1'b0, 1'b1, 1'b1, 32'h100, 32'h100, 32'h120, 1'b0, 1'b1, 32'h120);
        step(1'b0, 1'b1, 1'b1, 32'h100, 32'h100, 32'h120, 1'b0, 1'b1, 32'h120);
        chk("saturated_ctr", m_ctr[0] == 3 ? MispredCount : 32'hDEAD, 32'd1);
        // four not-taken resolutions walk the counter down, prediction carried from the predictor
        for (int n = 0; n < 4; n++)
            step(1'b0, 1'b1, 1'b0, 32'h100, 32'h100, 32'h120, 1'b1, 1'b0, 32'h0);
        lookup(32'h100);
        chk("ctr_floor_pred", {31'd0, PredTakenF}, 32'd0);
        chk("walkdown_mispred", MispredCount, 32'd3);
        // alias at same index replaces the entry
        step(1'b0, 1'b1, 1'b1, 32'h100, 32'h140, 32'h180, 1'b1, 1'b0, 32'h0);
        lookup(32'h100);
        lookup(32'h140);
        chk("alias_target", PredTargetF, 32'h180);
        // same-cycle lookup and update at one index
        step(1'b0, 1'b1, 1'b1, 32'h100, 32'h100, 32'h1A0, 1'b1, 1'b0, 32'h0);
        lookup(32'h100);
        // reset with a populated table and a concurrent branch
        step(1'b1, 1'b1, 1'b1, 32'h100, 32'h100, 32'h1C0, 1'b0, 1'b0, 32'h0);
        lookup(32'h100);
        lookup(32'h140);
        chk("post_reset_bc", BranchCount, 32'd0);
        // randomized traffic over a small aliasing PC pool
        for (int n = 0; n < 2000; n++) begin
            pc = pool[$urandom_range(0, 7)];
            tg = ($urandom_range(0, 1) == 1) ? 32'h120 : ($urandom & 32'hFFFF_FFFC);
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 pool[$urandom_range(0, 7)], pc, tg, ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? tg : 32'h120);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
